mem_port_arbiter: RTL and testbench

Arbitrates the single port of the shared 256×16 synchronous program/data memory between two requesters: the fetch stage (read-only) and the execute stage (load/store). Data accesses normally take priority, and a starvation counter guarantees that fetch gets a grant within a bounded number of cycles. The block tracks which requester owns each in-flight read and steers the 1-cycle-latency read data back to that requester.

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates one 256x16 sync memory port between fetch (read-only) and data (load/store).
// Latency : grant and memory access same cycle as request; read data returned exactly 1 cycle later.
// Backpres: losing requester holds its request; fetch is forced through after STARVE_LIMIT denials.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   f_req/f_addr -> f_gnt            fetch request and combinational grant
//   f_rvalid/f_rdata                 fetch read response (1 cycle after f_gnt)
//   d_req/d_we/d_addr/d_wdata        data request (write when d_we) and d_gnt
//   d_rvalid/d_rdata                 data read response (reads only)
//   mem_en/mem_we/mem_addr/mem_wdata memory command, mem_rdata memory read data
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  owner_t           resp_owner, resp_owner_nxt;

  // Grant decision. Gated by rst so nothing reaches the memory while in reset.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (f_req && (starve_cnt == CNT_MAX)) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  // Memory command; address/data forced to 0 on idle cycles.
  always_comb begin
    mem_en    = f_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Next-state: saturating starvation count and owner of next cycle's read data.
  always_comb begin
    starve_cnt_nxt = '0;
    if (f_req && !f_gnt) begin
      starve_cnt_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
    end

    resp_owner_nxt = OWN_NONE;
    if (f_gnt) begin
      resp_owner_nxt = OWN_FETCH;
    end else if (d_gnt && !d_we) begin
      resp_owner_nxt = OWN_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      resp_owner <= resp_owner_nxt;
    end
  end

  // Read data steering: the memory's 1-cycle read data goes to whoever owned the access.
  always_comb begin
    f_rvalid = (resp_owner == OWN_FETCH);
    d_rvalid = (resp_owner == OWN_DATA);
    f_rdata  = f_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter with a behavioural 256x16 memory.
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpres: requests held by the bench until granted, mirroring real requesters.
module tb_mem_port_arbiter;

  localparam logic [15:0] M01 = 16'h1111;
  localparam logic [15:0] M02 = 16'h2222;
  localparam logic [15:0] M05 = 16'hA1B2;
  localparam logic [15:0] M20 = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural synchronous memory; contents are (re)loaded on clock edges while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
      mem[8'h01] <= M01;
      mem[8'h02] <= M02;
      mem[8'h05] <= M05;
      mem[8'h20] <= M20;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; f_addr = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;
  endtask

  initial begin
    // ---------------- reset: requests present but fully gated ----------------
    rst = 1'b1;
    idle();
    f_req = 1'b1; f_addr = 8'h05; d_req = 1'b1; d_we = 1'b1; d_addr = 8'h33; d_wdata = 16'h5555;
    @(negedge clk);
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    next_cycle();
    rst = 1'b0;
    idle();

    // ---------------- fetch-only read ----------------
    f_req = 1'b1; f_addr = 8'h05;
    @(negedge clk);
    chk("fo_f_gnt", f_gnt, 1);
    chk("fo_d_gnt", d_gnt, 0);
    chk("fo_mem_en", mem_en, 1);
    chk("fo_mem_we", mem_we, 0);
    chk("fo_mem_addr", mem_addr, 8'h05);
    next_cycle();
    idle();
    @(negedge clk);
    chk("fo_f_rvalid", f_rvalid, 1);
    chk("fo_f_rdata", f_rdata, M05);
    chk("fo_d_rvalid", d_rvalid, 0);
    chk("fo_idle_mem_en", mem_en, 0);
    next_cycle();
    @(negedge clk);
    // memory output still holds the old word; steering must zero it
    chk("fo_after_f_rvalid", f_rvalid, 0);
    chk("fo_after_f_rdata", f_rdata, 0);

    // ---------------- data write then read ----------------
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_d_gnt", d_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 16'h1234);
    next_cycle();
    d_we = 1'b0; d_wdata = 16'h0000;
    @(negedge clk);
    chk("rd_d_gnt", d_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("wr_no_d_rvalid", d_rvalid, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("rd_d_rvalid", d_rvalid, 1);
    chk("rd_d_rdata", d_rdata, 16'h1234);
    chk("rd_f_rvalid", f_rvalid, 0);

    // ---------------- contention: data wins, then fetch ----------------
    next_cycle();
    f_req = 1'b1; f_addr = 8'h01;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    @(negedge clk);
    chk("ct_d_gnt", d_gnt, 1);
    chk("ct_f_gnt", f_gnt, 0);
    chk("ct_mem_addr", mem_addr, 8'h20);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk("ct2_f_gnt", f_gnt, 1);
    chk("ct2_mem_addr", mem_addr, 8'h01);
    chk("ct_d_rvalid", d_rvalid, 1);
    chk("ct_d_rdata", d_rdata, M20);
    chk("ct_f_rvalid", f_rvalid, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("ct2_f_rvalid", f_rvalid, 1);
    chk("ct2_f_rdata", f_rdata, M01);
    chk("ct2_d_rvalid", d_rvalid, 0);

    // ---------------- starvation: fetch forced in cycle 3 ----------------
    next_cycle();
    f_req = 1'b1; f_addr = 8'h01;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("sv_c%0d_d_gnt", c), d_gnt, 1);
      chk($sformatf("sv_c%0d_f_gnt", c), f_gnt, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("sv_c3_f_gnt", f_gnt, 1);
    chk("sv_c3_d_gnt", d_gnt, 0);
    chk("sv_c3_mem_addr", mem_addr, 8'h01);
    chk("sv_c3_d_rdata", d_rdata, M02);
    next_cycle();
    f_req = 1'b0;
    @(negedge clk);
    chk("sv_c4_d_gnt", d_gnt, 1);
    chk("sv_c4_f_rvalid", f_rvalid, 1);
    chk("sv_c4_f_rdata", f_rdata, M01);
    chk("sv_c4_d_rvalid", d_rvalid, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("sv_c5_d_rvalid", d_rvalid, 1);
    chk("sv_c5_d_rdata", d_rdata, M02);

    // ---------------- interleaved fetch/data every cycle ----------------
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      idle();
      if (k % 2 == 0) begin
        f_req = 1'b1; f_addr = 8'h01;
      end else begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
      end
      @(negedge clk);
      chk($sformatf("il%0d_f_gnt", k), f_gnt, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("il%0d_d_gnt", k), d_gnt, (k % 2 == 1) ? 1 : 0);
      if (k > 0) begin
        chk($sformatf("il%0d_f_rvalid", k), f_rvalid, (k % 2 == 1) ? 1 : 0);
        chk($sformatf("il%0d_d_rvalid", k), d_rvalid, (k % 2 == 0) ? 1 : 0);
        chk($sformatf("il%0d_f_rdata", k), f_rdata, (k % 2 == 1) ? M01 : 16'h0);
        chk($sformatf("il%0d_d_rdata", k), d_rdata, (k % 2 == 0) ? M02 : 16'h0);
      end
      chk($sformatf("il%0d_both_rvalid", k), f_rvalid & d_rvalid, 0);
    end

    // ---------------- reset mid-read ----------------
    next_cycle();
    idle();
    f_req = 1'b1; f_addr = 8'h05;
    @(negedge clk);
    chk("mr_f_gnt", f_gnt, 1);
    chk("mr_d_rvalid_pre", d_rvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_f_gnt_rst", f_gnt, 0);
    chk("mr_mem_en_rst", mem_en, 0);
    chk("mr_f_rvalid_rst", f_rvalid, 0);
    chk("mr_d_rvalid_rst", d_rvalid, 0);
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("mr_post_f_rvalid", f_rvalid, 0);
    chk("mr_post_d_rvalid", d_rvalid, 0);
    // counter restarted at 0: data keeps winning for three cycles before fetch is forced
    next_cycle();
    f_req = 1'b1; f_addr = 8'h01;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mr_c%0d_d_gnt", c), d_gnt, 1);
      next_cycle();
    end
    @(negedge clk);
    chk("mr_c3_f_gnt", f_gnt, 1);
    chk("mr_c3_d_gnt", d_gnt, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("mr_end_f_rvalid", f_rvalid, 1);
    chk("mr_end_f_rdata", f_rdata, M01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
